// File: rtl/proc_debug_ctrl_pkg.sv
// Shared opcodes, halt reasons and FSM state encoding for the debug run-control engine.
package proc_debug_ctrl_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_RESET  = 3'd1;
  localparam logic [2:0] OP_RUN    = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_HALT   = 3'd4;
  localparam logic [2:0] OP_SET_BP = 3'd5;
  localparam logic [2:0] OP_CLR_BP = 3'd6;
  localparam logic [2:0] OP_DUMP   = 3'd7;

  localparam logic [2:0] HR_RESET     = 3'd0;
  localparam logic [2:0] HR_HALT      = 3'd1;
  localparam logic [2:0] HR_STEP_DONE = 3'd2;
  localparam logic [2:0] HR_BP        = 3'd3;
  localparam logic [2:0] HR_PC_END    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RSTP = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_DUMP = 3'd4
  } state_t;

  // Commands that remain legal while the core is running or dumping.
  function automatic logic op_allowed_busy(input logic [2:0] op);
    return (op == OP_NOP) || (op == OP_RESET) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/proc_debug_ctrl_bp_match.sv
// Breakpoint slot registers plus comparator array; the lowest matching index wins.
module proc_debug_ctrl_bp_match #(
  parameter int PC_W   = 32,
  parameter int NUM_BP = 4
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            set_i,
  input  logic            clr_i,
  input  logic [2:0]      idx_i,
  input  logic [PC_W-1:0] addr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            hit_o,
  output logic [2:0]      hit_idx_o
);

  logic [PC_W-1:0]   r_addr [NUM_BP];
  logic [NUM_BP-1:0] r_en;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= '0;
      for (int i = 0; i < NUM_BP; i++) r_addr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (set_i && (idx_i == 3'(i))) begin
          r_en[i]   <= 1'b1;
          r_addr[i] <= addr_i;
        end else if (clr_i && (idx_i == 3'(i))) begin
          r_en[i] <= 1'b0;
        end
      end
    end
  end

  // Scan from the top down so the lowest matching slot is written last.
  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = 3'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (r_en[i] && (r_addr[i] == pc_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = 3'(i);
      end
    end
  end

endmodule

// File: rtl/proc_debug_ctrl.sv
// Run-control and debug readout between the UART command front end and the MIPS core:
// free run, N-step, halt, PC breakpoints, PC_END stop, timed core reset and register dump.
module proc_debug_ctrl
  import proc_debug_ctrl_pkg::*;
#(
  parameter int              PC_W    = 32,
  parameter int              DATA_W  = 32,
  parameter int              REG_AW  = 5,
  parameter int              NUM_BP  = 4,
  parameter logic [PC_W-1:0] PC_END  = 32'h48,
  parameter int              RST_CYC = 4,
  parameter int              CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [PC_W-1:0]   cmd_arg_i,
  input  logic [2:0]        cmd_idx_i,
  output logic              cmd_err_o,
  input  logic [PC_W-1:0]   pc_i,
  output logic              proc_run_en_o,
  output logic              proc_reset_o,
  output logic [REG_AW-1:0] reg_addr_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              halted_o,
  output logic [2:0]        halt_reason_o,
  output logic [2:0]        bp_hit_idx_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [2:0]        dbg_state_o
);

  localparam int              RW        = $clog2(RST_CYC + 1);
  localparam logic [REG_AW:0] LAST_WORD = {1'b1, {REG_AW{1'b0}}};

  state_t            r_state, w_state_nxt;
  logic              r_first;
  logic [PC_W-1:0]   r_step_cnt;
  logic [RW-1:0]     r_rst_cnt;
  logic [REG_AW:0]   r_word;
  logic [2:0]        r_reason, r_bp_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic w_cmd_acc, w_idx_ok, w_bp_hit, w_pc_end, w_hit, w_running;
  logic w_err, w_bp_set, w_bp_clr, w_reason_we, w_idx_we, w_step_load, w_dump_adv;
  logic [2:0] w_reason_nxt, w_bp_idx;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the sender holds its payload stable while valid is high and ready is low.
  assign cmd_ready_o = (r_state != S_RSTP);
  assign w_cmd_acc   = cmd_valid_i && cmd_ready_o;
  assign w_idx_ok    = ({1'b0, cmd_idx_i} < 4'(NUM_BP));
  assign w_running   = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_pc_end    = (pc_i == PC_END);
  // The first cycle after entry ignores matches so the core can resume from a stop PC.
  assign w_hit       = !r_first && (w_bp_hit || w_pc_end);

  proc_debug_ctrl_bp_match #(.PC_W(PC_W), .NUM_BP(NUM_BP)) u_bp_match (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .set_i     (w_bp_set),
    .clr_i     (w_bp_clr),
    .idx_i     (cmd_idx_i),
    .addr_i    (cmd_arg_i),
    .pc_i      (pc_i),
    .hit_o     (w_bp_hit),
    .hit_idx_o (w_bp_idx)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_err        = 1'b0;
    w_bp_set     = 1'b0;
    w_bp_clr     = 1'b0;
    w_reason_we  = 1'b0;
    w_reason_nxt = r_reason;
    w_idx_we     = 1'b0;
    w_step_load  = 1'b0;
    w_dump_adv   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_acc) begin
          case (cmd_op_i)
            OP_RESET:  w_state_nxt = S_RSTP;
            OP_RUN:    w_state_nxt = S_RUN;
            OP_STEP: begin
              w_state_nxt = S_STEP;
              w_step_load = 1'b1;
            end
            OP_DUMP:   w_state_nxt = S_DUMP;
            OP_SET_BP: if (w_idx_ok) w_bp_set = 1'b1; else w_err = 1'b1;
            OP_CLR_BP: if (w_idx_ok) w_bp_clr = 1'b1; else w_err = 1'b1;
            default: ;
          endcase
        end
      end
      S_RSTP: begin
        if (r_rst_cnt == RW'(RST_CYC - 1)) begin
          w_state_nxt  = S_IDLE;
          w_reason_we  = 1'b1;
          w_reason_nxt = HR_RESET;
        end
      end
      S_RUN, S_STEP: begin
        w_err = w_cmd_acc && !op_allowed_busy(cmd_op_i);
        if (w_cmd_acc && (cmd_op_i == OP_RESET)) begin
          w_state_nxt = S_RSTP;
        end else if (w_hit) begin
          w_state_nxt  = S_IDLE;
          w_reason_we  = 1'b1;
          w_reason_nxt = w_bp_hit ? HR_BP : HR_PC_END;
          w_idx_we     = w_bp_hit;
        end else if (w_cmd_acc && (cmd_op_i == OP_HALT)) begin
          w_state_nxt  = S_IDLE;
          w_reason_we  = 1'b1;
          w_reason_nxt = HR_HALT;
        end else if ((r_state == S_STEP) && (r_step_cnt == PC_W'(1))) begin
          w_state_nxt  = S_IDLE;
          w_reason_we  = 1'b1;
          w_reason_nxt = HR_STEP_DONE;
        end
      end
      S_DUMP: begin
        w_err = w_cmd_acc && !op_allowed_busy(cmd_op_i);
        if (w_cmd_acc && (cmd_op_i == OP_RESET)) begin
          w_state_nxt = S_RSTP;
        end else if (dump_ready_i) begin
          w_dump_adv = 1'b1;
          if (r_word == LAST_WORD) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_first    <= 1'b1;
      r_step_cnt <= '0;
      r_rst_cnt  <= '0;
      r_word     <= '0;
      r_reason   <= HR_RESET;
      r_bp_idx   <= 3'd0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_err     <= w_err;
      r_first   <= !w_running;
      r_rst_cnt <= (r_state == S_RSTP) ? r_rst_cnt + RW'(1) : '0;
      if (w_step_load) r_step_cnt <= (cmd_arg_i == '0) ? PC_W'(1) : cmd_arg_i;
      else if ((r_state == S_STEP) && proc_run_en_o) r_step_cnt <= r_step_cnt - PC_W'(1);
      if (w_state_nxt != S_DUMP) r_word <= '0;
      else if (w_dump_adv) r_word <= r_word + 1'b1;
      if (w_reason_we) r_reason <= w_reason_nxt;
      if (w_idx_we) r_bp_idx <= w_bp_idx;
      if (r_state == S_RSTP) r_cnt <= '0;
      else if (proc_run_en_o && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign proc_run_en_o = w_running && !w_hit;
  assign proc_reset_o  = (r_state == S_RSTP);
  assign dump_valid_o  = (r_state == S_DUMP);
  assign reg_addr_o    = r_word[REG_AW-1:0];
  assign dump_data_o   = r_word[REG_AW] ? DATA_W'(pc_i) : reg_rdata_i;
  assign halted_o      = (r_state == S_IDLE);
  assign halt_reason_o = r_reason;
  assign bp_hit_idx_o  = r_bp_idx;
  assign cycle_cnt_o   = r_cnt;
  assign cmd_err_o     = r_err;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_proc_debug_ctrl.sv
// Directed bench for proc_debug_ctrl with a tiny core PC model and a patterned register file.
`timescale 1ns/1ps
module tb_proc_debug_ctrl;

  localparam logic [2:0] OP_RESET = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3, OP_HALT = 3'd4;
  localparam logic [2:0] OP_SET_BP = 3'd5, OP_CLR_BP = 3'd6, OP_DUMP = 3'd7;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [2:0]  cmd_op_i = 3'd0;
  logic [31:0] cmd_arg_i = 32'd0;
  logic [2:0]  cmd_idx_i = 3'd0;
  logic        cmd_err_o;
  logic [31:0] pc_i;
  logic        proc_run_en_o, proc_reset_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_rdata_i;
  logic        dump_valid_o;
  logic        dump_ready_i = 1'b0;
  logic [31:0] dump_data_o;
  logic        halted_o;
  logic [2:0]  halt_reason_o, bp_hit_idx_o, dbg_state_o;
  logic [31:0] cycle_cnt_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  proc_debug_ctrl dut (
    .clk_i(clk_i), .rst_n(rst_n), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_arg_i(cmd_arg_i), .cmd_idx_i(cmd_idx_i), .cmd_err_o(cmd_err_o),
    .pc_i(pc_i), .proc_run_en_o(proc_run_en_o), .proc_reset_o(proc_reset_o),
    .reg_addr_o(reg_addr_o), .reg_rdata_i(reg_rdata_i), .dump_valid_o(dump_valid_o),
    .dump_ready_i(dump_ready_i), .dump_data_o(dump_data_o), .halted_o(halted_o),
    .halt_reason_o(halt_reason_o), .bp_hit_idx_o(bp_hit_idx_o), .cycle_cnt_o(cycle_cnt_o),
    .dbg_state_o(dbg_state_o)
  );

  // Core model: PC advances by one word per enabled cycle, cleared by the core reset.
  logic [31:0] core_pc;
  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) core_pc <= 32'd0;
    else if (proc_reset_o) core_pc <= 32'd0;
    else if (proc_run_en_o) core_pc <= core_pc + 32'd4;
  end
  assign pc_i = core_pc;
  assign reg_rdata_i = {24'hC0FFEE, 3'b000, reg_addr_o};

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] arg, input logic [2:0] idx);
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_arg_i = arg; cmd_idx_i = idx;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0; cmd_op_i = 3'd0; cmd_arg_i = 32'd0; cmd_idx_i = 3'd0;
  endtask

  task automatic wait_halt(output int en_cycles);
    en_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      if (halted_o) break;
      if (proc_run_en_o) en_cycles++;
      @(posedge clk_i); #1;
    end
    checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL halt_timeout: halted=%b required 1", halted_o); end
  endtask

  task automatic do_reset(output int rst_cycles);
    send_cmd(OP_RESET, 32'd0, 3'd0);
    rst_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (!proc_reset_o) break;
      rst_cycles++;
      @(posedge clk_i); #1;
    end
    checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL reset_timeout: halted=%b required 1", halted_o); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL rst_halted: got %b required 1", halted_o); end
    checks++; if ({proc_run_en_o, proc_reset_o, dump_valid_o, cmd_err_o} !== 4'b0000) begin errors++; $display("FAIL rst_ctrl: got %b required 0000", {proc_run_en_o, proc_reset_o, dump_valid_o, cmd_err_o}); end
    checks++; if (halt_reason_o !== 3'd0 || bp_hit_idx_o !== 3'd0) begin errors++; $display("FAIL rst_reason: got %0d/%0d required 0/0", halt_reason_o, bp_hit_idx_o); end
    checks++; if (cycle_cnt_o !== 32'd0 || reg_addr_o !== 5'd0) begin errors++; $display("FAIL rst_cnt_addr: got %0d/%0d required 0/0", cycle_cnt_o, reg_addr_o); end
    @(negedge clk_i); rst_n = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", cmd_ready_o); end
  endtask

  task automatic test_reset_cmd();
    int n;
    send_cmd(OP_RESET, 32'd0, 3'd0);
    checks++; if (cmd_ready_o !== 1'b0 || dbg_state_o !== 3'd1) begin errors++; $display("FAIL rstp_entry: ready=%b state=%0d required 0/1", cmd_ready_o, dbg_state_o); end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!proc_reset_o) break;
      if (proc_run_en_o) begin errors++; $display("FAIL rstp_run_en: got 1 required 0"); end
      n++;
      @(posedge clk_i); #1;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL rstp_len: got %0d cycles required 4", n); end
    checks++; if (halted_o !== 1'b1 || halt_reason_o !== 3'd0) begin errors++; $display("FAIL rstp_done: halted=%b reason=%0d required 1/0", halted_o, halt_reason_o); end
    checks++; if (cycle_cnt_o !== 32'd0) begin errors++; $display("FAIL rstp_cnt: got %0d required 0", cycle_cnt_o); end
  endtask

  task automatic test_bp_run();
    int en;
    send_cmd(OP_SET_BP, 32'h10, 3'd0);
    checks++; if (cmd_err_o !== 1'b0) begin errors++; $display("FAIL setbp_err: got %b required 0", cmd_err_o); end
    send_cmd(OP_RUN, 32'd0, 3'd0);
    wait_halt(en);
    checks++; if (en !== 4) begin errors++; $display("FAIL bp_en_cycles: got %0d required 4", en); end
    checks++; if (pc_i !== 32'h10) begin errors++; $display("FAIL bp_pc: got %h required 00000010", pc_i); end
    checks++; if (halt_reason_o !== 3'd3 || bp_hit_idx_o !== 3'd0) begin errors++; $display("FAIL bp_reason: got %0d/%0d required 3/0", halt_reason_o, bp_hit_idx_o); end
    checks++; if (cycle_cnt_o !== 32'd4) begin errors++; $display("FAIL bp_cnt: got %0d required 4", cycle_cnt_o); end
  endtask

  task automatic test_resume_pc_end();
    int en;
    send_cmd(OP_RUN, 32'd0, 3'd0);
    wait_halt(en);
    checks++; if (en !== 14) begin errors++; $display("FAIL end_en_cycles: got %0d required 14", en); end
    checks++; if (pc_i !== 32'h48 || halt_reason_o !== 3'd4) begin errors++; $display("FAIL end_stop: pc=%h reason=%0d required 00000048/4", pc_i, halt_reason_o); end
    checks++; if (cycle_cnt_o !== 32'd18) begin errors++; $display("FAIL end_cnt: got %0d required 18", cycle_cnt_o); end
  endtask

  task automatic test_step();
    int en, n;
    do_reset(n);
    send_cmd(OP_STEP, 32'd3, 3'd0);
    wait_halt(en);
    checks++; if (en !== 3 || pc_i !== 32'hC) begin errors++; $display("FAIL step3: en=%0d pc=%h required 3/0000000c", en, pc_i); end
    checks++; if (halt_reason_o !== 3'd2 || cycle_cnt_o !== 32'd3) begin errors++; $display("FAIL step3_state: reason=%0d cnt=%0d required 2/3", halt_reason_o, cycle_cnt_o); end
    send_cmd(OP_STEP, 32'd0, 3'd0);
    wait_halt(en);
    checks++; if (en !== 1 || pc_i !== 32'h10) begin errors++; $display("FAIL step0: en=%0d pc=%h required 1/00000010", en, pc_i); end
    checks++; if (halt_reason_o !== 3'd2 || cycle_cnt_o !== 32'd4) begin errors++; $display("FAIL step0_state: reason=%0d cnt=%0d required 2/4", halt_reason_o, cycle_cnt_o); end
  endtask

  task automatic test_dump();
    int words;
    logic stalled;
    logic [31:0] held, exp;
    for (int k = 0; k < 32; k++) exp_q.push_back({24'hC0FFEE, 3'b000, k[4:0]});
    exp_q.push_back(32'h10);
    send_cmd(OP_DUMP, 32'd0, 3'd0);
    words = 0; stalled = 1'b0; held = 32'd0;
    for (int cyc = 0; cyc < 300 && words < 33; cyc++) begin
      dump_ready_i = cyc[0];
      @(negedge clk_i);
      if (dump_valid_o) begin
        if (stalled) begin
          checks++; if (dump_data_o !== held) begin errors++; $display("FAIL dump_stall: got %h required %h", dump_data_o, held); end
        end
        if (dump_ready_i) begin
          exp = exp_q.pop_front();
          checks++; if (dump_data_o !== exp) begin errors++; $display("FAIL dump_word%0d: got %h required %h", words, dump_data_o, exp); end
          words++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; held = dump_data_o;
        end
      end
      @(posedge clk_i); #1;
    end
    dump_ready_i = 1'b0;
    checks++; if (words !== 33) begin errors++; $display("FAIL dump_count: got %0d required 33", words); end
    checks++; if (halted_o !== 1'b1 || dump_valid_o !== 1'b0 || halt_reason_o !== 3'd2) begin errors++; $display("FAIL dump_end: halted=%b valid=%b reason=%0d required 1/0/2", halted_o, dump_valid_o, halt_reason_o); end
    exp_q.delete();
  endtask

  task automatic test_bp_priority();
    int en, n;
    do_reset(n);
    send_cmd(OP_SET_BP, 32'h8, 3'd2);
    send_cmd(OP_SET_BP, 32'h8, 3'd1);
    send_cmd(OP_SET_BP, 32'h0, 3'd5);
    checks++; if (cmd_err_o !== 1'b1) begin errors++; $display("FAIL bad_idx_set: err=%b required 1", cmd_err_o); end
    send_cmd(OP_RUN, 32'd0, 3'd0);
    checks++; if (cmd_err_o !== 1'b0) begin errors++; $display("FAIL err_pulse_len: err=%b required 0", cmd_err_o); end
    wait_halt(en);
    checks++; if (en !== 2 || pc_i !== 32'h8) begin errors++; $display("FAIL prio_stop: en=%0d pc=%h required 2/00000008", en, pc_i); end
    checks++; if (halt_reason_o !== 3'd3 || bp_hit_idx_o !== 3'd1) begin errors++; $display("FAIL prio_idx: reason=%0d idx=%0d required 3/1", halt_reason_o, bp_hit_idx_o); end
    send_cmd(OP_CLR_BP, 32'd0, 3'd1);
    send_cmd(OP_CLR_BP, 32'd0, 3'd2);
    send_cmd(OP_CLR_BP, 32'd0, 3'd4);
    checks++; if (cmd_err_o !== 1'b1) begin errors++; $display("FAIL bad_idx_clr: err=%b required 1", cmd_err_o); end
  endtask

  task automatic test_halt_vs_bp();
    int n;
    do_reset(n);
    send_cmd(OP_RUN, 32'd0, 3'd0);
    repeat (4) begin @(posedge clk_i); #1; end
    checks++; if (pc_i !== 32'h10 || proc_run_en_o !== 1'b0) begin errors++; $display("FAIL hvb_at_bp: pc=%h en=%b required 00000010/0", pc_i, proc_run_en_o); end
    send_cmd(OP_HALT, 32'd0, 3'd0);
    checks++; if (halted_o !== 1'b1 || halt_reason_o !== 3'd3 || bp_hit_idx_o !== 3'd0) begin errors++; $display("FAIL hvb_reason: halted=%b reason=%0d idx=%0d required 1/3/0", halted_o, halt_reason_o, bp_hit_idx_o); end
    checks++; if (cmd_err_o !== 1'b0) begin errors++; $display("FAIL hvb_err: got %b required 0", cmd_err_o); end
  endtask

  task automatic test_run_while_run();
    int n;
    do_reset(n);
    send_cmd(OP_RUN, 32'd0, 3'd0);
    send_cmd(OP_RUN, 32'd0, 3'd0);
    checks++; if (cmd_err_o !== 1'b1 || dbg_state_o !== 3'd2 || halted_o !== 1'b0) begin errors++; $display("FAIL rwr_err: err=%b state=%0d halted=%b required 1/2/0", cmd_err_o, dbg_state_o, halted_o); end
    send_cmd(OP_HALT, 32'd0, 3'd0);
    checks++; if (cmd_err_o !== 1'b0 || halted_o !== 1'b1 || halt_reason_o !== 3'd1) begin errors++; $display("FAIL rwr_halt: err=%b halted=%b reason=%0d required 0/1/1", cmd_err_o, halted_o, halt_reason_o); end
    checks++; if (pc_i !== 32'h8 || cycle_cnt_o !== 32'd2) begin errors++; $display("FAIL rwr_pc: pc=%h cnt=%0d required 00000008/2", pc_i, cycle_cnt_o); end
  endtask

  task automatic test_reset_vs_bp();
    int n;
    do_reset(n);
    send_cmd(OP_RUN, 32'd0, 3'd0);
    repeat (4) begin @(posedge clk_i); #1; end
    send_cmd(OP_RESET, 32'd0, 3'd0);
    checks++; if (proc_reset_o !== 1'b1 || dbg_state_o !== 3'd1) begin errors++; $display("FAIL rvb_state: rst=%b state=%0d required 1/1", proc_reset_o, dbg_state_o); end
    n = 0;
    for (int i = 0; i < 20 && proc_reset_o; i++) begin n++; @(posedge clk_i); #1; end
    checks++; if (n !== 4 || halt_reason_o !== 3'd0 || cycle_cnt_o !== 32'd0) begin errors++; $display("FAIL rvb_done: len=%0d reason=%0d cnt=%0d required 4/0/0", n, halt_reason_o, cycle_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_reset_cmd();
    test_bp_run();
    test_resume_pc_end();
    test_step();
    test_dump();
    test_bp_priority();
    test_halt_vs_bp();
    test_run_while_run();
    test_reset_vs_bp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
